// File: rtl/adld_pkg.sv
// Shared types and default sizing for the multi-cycle chunked adder.
package adld_pkg;
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   localparam int WIDTH_DEF = 16;
   localparam int SLICE_DEF = 4;
endpackage

// File: rtl/chunked_adder_rca_slice.sv
// Combinational SLICE-bit adder reused on every ADD cycle; also exposes the
// carry into its top bit so the parent can derive signed overflow.
module rca_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co,
   output logic             c_msb_in
);
   logic [SLICE:0] w_sum;

   assign w_sum    = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
   assign s        = w_sum[SLICE-1:0];
   assign co       = w_sum[SLICE];
   // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
   assign c_msb_in = a[SLICE-1] ^ b[SLICE-1] ^ s[SLICE-1];
endmodule

// File: rtl/chunked_adder.sv
// Serial add/subtract: one SLICE-bit chunk per clock, LSB chunk first,
// with a one-cycle done pulse once S, Cout and V are complete.
module chunked_adder
   import adld_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             SUB,
   input  logic             Cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             busy,
   output logic             done
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_sub;
   logic               r_carry;

   logic [SLICE-1:0]   w_a;
   logic [SLICE-1:0]   w_b;
   logic [SLICE-1:0]   w_s;
   logic               w_co;
   logic               w_c_msb;

   // Subtraction is A + ~B + 1: the +1 comes from the carry preload.
   assign w_a = r_a[r_idx*SLICE +: SLICE];
   assign w_b = r_b[r_idx*SLICE +: SLICE] ^ {SLICE{r_sub}};

   rca_slice #(.SLICE(SLICE)) u_slice (
      .a        (w_a),
      .b        (w_b),
      .ci       (r_carry),
      .s        (w_s),
      .co       (w_co),
      .c_msb_in (w_c_msb)
   );

   // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         S       <= '0;
         Cout    <= 1'b0;
         V       <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_sub   <= SUB;
                  r_carry <= SUB | Cin;
                  r_idx   <= '0;
                  busy    <= 1'b1;
                  r_state <= ADD;
               end
            end
            ADD: begin
               S[r_idx*SLICE +: SLICE] <= w_s;
               r_carry                 <= w_co;
               if (r_idx == LAST_IDX) begin
                  Cout    <= w_co;
                  V       <= w_c_msb ^ w_co;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
